// File: rtl/inst_fetch_if.sv
// Fetch-unit bundle: PC handshake, instruction-memory request/response and decode channel.
interface inst_fetch_if;
    logic [31:0] pc;
    logic        pc_en;
    logic        flush;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        if_exc;

    modport master (
        input  pc, flush, imem_req_ready, imem_resp_valid, imem_resp_data, if_ready,
        output pc_en, imem_req_valid, imem_req_addr, if_valid, if_instr, if_pc, if_exc
    );

    modport slave (
        output pc, flush, imem_req_ready, imem_resp_valid, imem_resp_data, if_ready,
        input  pc_en, imem_req_valid, imem_req_addr, if_valid, if_instr, if_pc, if_exc
    );
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch: at most two fetches in flight or queued, in-order delivery to decode.
// Define IFETCH_MISALIGN_CHK_EN to turn misaligned PCs into exception entries.
module inst_fetch (
    input  logic         clk,
    input  logic         rst,
    inst_fetch_if.master bus
);
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        exc;
    } entry_t;

    entry_t      q    [2];
    logic [31:0] pend [2];
    logic [1:0]  q_cnt, out_cnt, drop_cnt;

    logic       aligned, exc_ins, room, req_fire;
    logic       resp_acc, resp_keep, enq, deq, wr_slot, push_slot;
    logic [1:0] out_nxt;
    entry_t     enq_e;

`ifdef IFETCH_MISALIGN_CHK_EN
    assign aligned = (bus.pc[1:0] == 2'b00);
    assign exc_ins = !rst && !bus.flush && !aligned && (out_cnt == 2'd0) && (q_cnt != 2'd2);
`else
    assign aligned = 1'b1;
    assign exc_ins = 1'b0;
`endif

    // Queue slots are reserved at request time, so a response can always be enqueued.
    assign room               = ({1'b0, out_cnt} + {1'b0, q_cnt}) < 3'd2;
    assign bus.imem_req_valid = !rst && !bus.flush && room && aligned;
    assign bus.imem_req_addr  = {bus.pc[31:2], 2'b00};
    assign req_fire           = bus.imem_req_valid && bus.imem_req_ready;
    assign bus.pc_en          = req_fire || exc_ins;

    assign resp_acc  = bus.imem_resp_valid && (out_cnt != 2'd0);
    assign resp_keep = resp_acc && (drop_cnt == 2'd0) && !bus.flush;
    assign enq       = resp_keep || exc_ins;
    assign deq       = (q_cnt != 2'd0) && bus.if_ready;
    assign out_nxt   = out_cnt + {1'b0, req_fire} - {1'b0, resp_acc};

    assign wr_slot   = deq ? (q_cnt == 2'd2) : (q_cnt == 2'd1);
    assign push_slot = out_cnt[0] && !resp_acc;

    always_comb begin
        enq_e = '{pc: pend[0], instr: bus.imem_resp_data, exc: 1'b0};
        if (exc_ins)
            enq_e = '{pc: bus.pc, instr: 32'h0000_0000, exc: 1'b1};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q[0]     <= '0;
            q[1]     <= '0;
            pend[0]  <= '0;
            pend[1]  <= '0;
            q_cnt    <= '0;
            out_cnt  <= '0;
            drop_cnt <= '0;
        end else begin
            if (resp_acc) pend[0] <= pend[1];
            if (req_fire) pend[push_slot] <= bus.pc;
            out_cnt <= out_nxt;

            if (bus.flush) begin
                q_cnt    <= '0;
                drop_cnt <= out_nxt;
            end else begin
                if (deq) q[0] <= q[1];
                if (enq) q[wr_slot] <= enq_e;
                q_cnt    <= q_cnt + {1'b0, enq} - {1'b0, deq};
                drop_cnt <= drop_cnt - {1'b0, resp_acc && (drop_cnt != 2'd0)};
            end
        end
    end

    // Without the misalign check the exc flag is only ever written as 0.
    assign bus.if_valid = (q_cnt != 2'd0);
    assign bus.if_instr = q[0].instr;
    assign bus.if_pc    = q[0].pc;
    assign bus.if_exc   = q[0].exc;
endmodule

// File: tb/tb_inst_fetch.sv
// Scoreboard bench for inst_fetch: stimulus pushes expected entries, a monitor pops on if_valid & if_ready.
module tb_inst_fetch;
    logic clk;
    logic rst;

    inst_fetch_if bus ();
    inst_fetch u_dut (.clk(clk), .rst(rst), .bus(bus));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        exc;
    } exp_t;

    exp_t        expq [$];
    logic [31:0] memq [$];
    int          nerr = 0;
    int          nchk = 0;
    logic        auto_pc, mem_stall, last_hs;

    function automatic logic [31:0] memf(logic [31:0] a);
        return 32'hC0DE_0000 + a;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One clock: sample at negedge, act as PC register and 1-cycle memory after posedge.
    task automatic tick();
        logic hs, pe, fl;
        logic [31:0] pcs;
        @(negedge clk);
        hs  = bus.imem_req_valid && bus.imem_req_ready;
        pe  = bus.pc_en;
        fl  = bus.flush;
        pcs = bus.pc;
        if (hs) chk("req_addr", bus.imem_req_addr, {pcs[31:2], 2'b00});
        @(posedge clk);
        #1;
        last_hs = hs;
        if (rst) memq.delete();
        if (fl) expq.delete();
        if (hs) begin
            memq.push_back({pcs[31:2], 2'b00});
            expq.push_back({pcs, memf({pcs[31:2], 2'b00}), 1'b0});
        end else if (pe) begin
            expq.push_back({pcs, 32'h0000_0000, 1'b1});
        end
        if (pe && auto_pc) bus.pc = pcs + 32'd4;
        if (!mem_stall && memq.size() != 0) begin
            bus.imem_resp_valid = 1'b1;
            bus.imem_resp_data  = memf(memq.pop_front());
        end else begin
            bus.imem_resp_valid = 1'b0;
            bus.imem_resp_data  = 32'h0;
        end
        #1;
    endtask

    task automatic drain(string nm);
        for (int i = 0; i < 20; i++) begin
            if (expq.size() == 0 && memq.size() == 0 && !bus.if_valid) break;
            tick();
        end
        chk(nm, expq.size(), 0);
    endtask

    task automatic wait_hs(string nm, int lim);
        for (int i = 0; i < lim; i++) begin
            tick();
            if (last_hs) break;
        end
        chk(nm, last_hs, 1);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst === 1'b0 && bus.if_valid && bus.if_ready) begin
                if (expq.size() == 0) begin
                    nchk++;
                    nerr++;
                    $display("FAIL if_unexpected: got pc %h expected none", bus.if_pc);
                end else begin
                    e = expq.pop_front();
                    chk("if_pc", bus.if_pc, e.pc);
                    chk("if_instr", bus.if_instr, e.instr);
                    chk("if_exc", bus.if_exc, e.exc);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        bus.pc = 32'h0; bus.flush = 1'b0;
        bus.imem_req_ready = 1'b0; bus.if_ready = 1'b0;
        bus.imem_resp_valid = 1'b0; bus.imem_resp_data = 32'h0;
        auto_pc = 1'b0; mem_stall = 1'b0; last_hs = 1'b0;

        // Reset
        tick(); tick();
        chk("rst_req_valid", bus.imem_req_valid, 0);
        chk("rst_pc_en",     bus.pc_en, 0);
        chk("rst_if_valid",  bus.if_valid, 0);
        chk("rst_if_pc",     bus.if_pc, 0);
        chk("rst_if_instr",  bus.if_instr, 0);
        chk("rst_if_exc",    bus.if_exc, 0);
        rst = 1'b0;
        #1;
        chk("rel_req_valid", bus.imem_req_valid, 1);
        chk("rel_req_addr",  bus.imem_req_addr, 32'h0);

        // Streaming 0x0, 0x4, 0x8
        bus.imem_req_ready = 1'b1; bus.if_ready = 1'b1; auto_pc = 1'b1;
        tick();
        chk("lat1_if_valid", bus.if_valid, 0);
        tick();
        chk("lat2_if_valid", bus.if_valid, 1);
        chk("lat2_if_pc",    bus.if_pc, 32'h0);
        chk("lat2_if_instr", bus.if_instr, 32'hC0DE_0000);
        for (int i = 0; i < 12; i++) begin
            if (bus.pc == 32'hC) break;
            tick();
        end
        bus.imem_req_ready = 1'b0;
        chk("stream_pc", bus.pc, 32'hC);
        drain("stream_drain");

        // Backpressure with two queued entries
        bus.if_ready = 1'b0; bus.imem_req_ready = 1'b1;
        repeat (4) tick();
        chk("bp_req_valid", bus.imem_req_valid, 0);
        chk("bp_pc_en",     bus.pc_en, 0);
        chk("bp_if_valid",  bus.if_valid, 1);
        chk("bp_if_pc",     bus.if_pc, 32'hC);
        chk("bp_if_instr",  bus.if_instr, 32'hC0DE_000C);
        tick();
        chk("bp_hold_instr", bus.if_instr, 32'hC0DE_000C);
        chk("bp_hold_pc",    bus.if_pc, 32'hC);
        bus.if_ready = 1'b1;
        wait_hs("bp_resume", 6);
        bus.imem_req_ready = 1'b0;
        drain("bp_drain");

        // Flush with 0x10 and 0x14 outstanding, refetch 0x40
        bus.pc = 32'h10; mem_stall = 1'b1; bus.imem_req_ready = 1'b1;
        tick(); tick();
        bus.flush = 1'b1;
        #1;
        chk("fl_req_valid", bus.imem_req_valid, 0);
        tick();
        bus.flush = 1'b0; bus.pc = 32'h40; mem_stall = 1'b0;
        #1;
        chk("fl_if_valid", bus.if_valid, 0);
        wait_hs("fl_refetch", 8);
        bus.imem_req_ready = 1'b0;
        drain("fl_drain");

        // Flush while a response lands in the same cycle
        bus.pc = 32'h20; mem_stall = 1'b1; bus.imem_req_ready = 1'b1;
        tick();
        mem_stall = 1'b0;
        tick();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0; bus.pc = 32'h80;
        #1;
        chk("f2_req_valid", bus.imem_req_valid, 1);
        chk("f2_req_addr",  bus.imem_req_addr, 32'h80);
        tick();
        bus.imem_req_ready = 1'b0;
        drain("f2_drain");

        // Flush with a full queue
        bus.if_ready = 1'b0; bus.pc = 32'h300; bus.imem_req_ready = 1'b1;
        repeat (4) tick();
        bus.imem_req_ready = 1'b0; bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        #1;
        chk("fq_if_valid", bus.if_valid, 0);
        bus.if_ready = 1'b1;
        drain("fq_drain");

        // Misaligned PC
        auto_pc = 1'b0; bus.pc = 32'h102; bus.if_ready = 1'b1;
`ifdef IFETCH_MISALIGN_CHK_EN
        bus.imem_req_ready = 1'b1;
        #1;
        chk("ma_req_valid", bus.imem_req_valid, 0);
        chk("ma_pc_en",     bus.pc_en, 1);
        tick();
        bus.pc = 32'h200; bus.imem_req_ready = 1'b0;
        #1;
        chk("ma_if_valid", bus.if_valid, 1);
        chk("ma_if_pc",    bus.if_pc, 32'h102);
        chk("ma_if_exc",   bus.if_exc, 1);
        chk("ma_if_instr", bus.if_instr, 32'h0);
`else
        bus.imem_req_ready = 1'b0;
        #1;
        chk("ma_req_valid", bus.imem_req_valid, 1);
        chk("ma_req_addr",  bus.imem_req_addr, 32'h100);
        chk("ma_pc_en",     bus.pc_en, 0);
        bus.imem_req_ready = 1'b1;
        tick();
        bus.imem_req_ready = 1'b0;
`endif
        drain("ma_drain");

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
